// File: rtl/nor_bus_sequencer_if.sv
// nor_bus_sequencer_if: Wishbone-side request/response bundle for nor_bus_sequencer.
interface nor_bus_sequencer_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [25:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wait_ry_i;
   logic        busy_o;
   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wait_ry_i,
      output wb_dat_o, wb_ack_o, wb_err_o, busy_o
   );
   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wait_ry_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, busy_o
   );
endinterface

// File: rtl/nor_bus_sequencer.sv
// nor_bus_sequencer: Wishbone slave sequencing single 16-bit async NOR read/write cycles.
// Define NOR_BUSY_TIMEOUT_EN to bound WAIT_RY and report expiry on wb_err_o.
module nor_bus_sequencer #(
   parameter int T_SETUP      = 2,
   parameter int T_RD         = 6,
   parameter int T_WR         = 4,
   parameter int T_HOLD       = 1,
   parameter int T_RECOVER    = 2,
   parameter int T_BUSY_START = 4,
   parameter int BUSY_TIMEOUT = 1000,
   parameter int CNT_W        = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   nor_bus_sequencer_if.slave wb,
   output logic [25:0]        nor_addr_o,
   output logic [15:0]        nor_data_o,
   output logic               nor_data_oe,
   input  logic [15:0]        nor_data_i,
   output logic               nor_ce_o,
   output logic               nor_oe_o,
   output logic               nor_we_o,
   input  logic               nor_ry_i
);
   typedef enum logic [2:0] {IDLE, SETUP, RD_STB, WR_STB, HOLD, WAIT_RY, ACK, RECOVER} state_t;
   localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] L_RD    = CNT_W'(T_RD - 1);
   localparam logic [CNT_W-1:0] L_WR    = CNT_W'(T_WR - 1);
   localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] L_REC   = CNT_W'(T_RECOVER - 1);
   localparam logic [CNT_W-1:0] L_BUSY  = CNT_W'(T_BUSY_START);
   state_t           state_q, state_d, strobe_st, post_st;
   logic [CNT_W-1:0] cnt_q, cnt_d, strobe_len;
   logic [1:0]       ry_q;
   logic             we_q, we_d, wait_q, accept, done, timeout;
   assign done       = cnt_q == '0;
   assign accept     = state_q == IDLE && wb.wb_cyc_i && wb.wb_stb_i;
   assign we_d       = accept ? wb.wb_we_i : we_q;
   assign strobe_st  = we_d ? WR_STB : RD_STB;
   assign strobe_len = we_d ? L_WR : L_RD;
   assign post_st    = (we_q && wait_q) ? WAIT_RY : ACK;
`ifdef NOR_BUSY_TIMEOUT_EN
   localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
   logic [TO_W-1:0] to_q;
   always_ff @(posedge clk_i) begin
      if (reset_i || state_q != WAIT_RY) to_q <= '0;
      else to_q <= to_q + 1'b1;
   end
   assign timeout = state_q == WAIT_RY && to_q == TO_W'(BUSY_TIMEOUT - 1) && !(done && ry_q[1]);
`else
   assign timeout = BUSY_TIMEOUT < 0;
`endif
   // WAIT_RY: counter first masks RY for the device tBUSY window, then RY gates exit
   always_comb begin
      state_d = state_q;
      cnt_d   = done ? cnt_q : cnt_q - 1'b1;
      case (state_q)
         IDLE: if (accept) begin
            state_d = (T_SETUP > 0) ? SETUP : strobe_st;
            cnt_d   = (T_SETUP > 0) ? L_SETUP : strobe_len;
         end
         SETUP: if (done) begin
            state_d = strobe_st;
            cnt_d   = strobe_len;
         end
         RD_STB, WR_STB: if (done) begin
            state_d = (T_HOLD > 0) ? HOLD : post_st;
            cnt_d   = (T_HOLD > 0) ? L_HOLD : L_BUSY;
         end
         HOLD: if (done) begin
            state_d = post_st;
            cnt_d   = L_BUSY;
         end
         WAIT_RY: if ((done && ry_q[1]) || timeout) state_d = ACK;
         ACK: begin
            state_d = (T_RECOVER > 0) ? RECOVER : IDLE;
            cnt_d   = L_REC;
         end
         RECOVER: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Pad outputs are registered decodes of the next state so they align with state_q
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ry_q        <= 2'b11;
         we_q        <= 1'b0;
         wait_q      <= 1'b0;
         nor_addr_o  <= '0;
         nor_data_o  <= '0;
         wb.wb_dat_o <= '0;
         nor_ce_o    <= 1'b1;
         nor_oe_o    <= 1'b1;
         nor_we_o    <= 1'b1;
         nor_data_oe <= 1'b0;
         wb.wb_ack_o <= 1'b0;
         wb.wb_err_o <= 1'b0;
         wb.busy_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ry_q    <= {ry_q[0], nor_ry_i};
         we_q    <= we_d;
         if (accept) begin
            wait_q     <= wb.wait_ry_i;
            nor_addr_o <= wb.wb_adr_i;
            nor_data_o <= wb.wb_dat_i;
         end
         if (state_q == RD_STB && done) wb.wb_dat_o <= nor_data_i;
         nor_ce_o    <= !(state_d inside {SETUP, RD_STB, WR_STB, HOLD});
         nor_oe_o    <= state_d != RD_STB;
         nor_we_o    <= state_d != WR_STB;
         nor_data_oe <= we_d && (state_d inside {SETUP, WR_STB, HOLD});
         wb.wb_ack_o <= state_d == ACK && !timeout && wb.wb_cyc_i;
         wb.wb_err_o <= state_d == ACK && timeout && wb.wb_cyc_i;
         wb.busy_o   <= state_d != IDLE;
      end
   end
endmodule

// File: tb/tb_nor_bus_sequencer.sv
// tb_nor_bus_sequencer: directed stimulus with a queued scoreboard for nor_bus_sequencer.
module tb_nor_bus_sequencer;
   typedef struct {logic err; logic chk; logic [15:0] dat; int due;} exp_t;
   logic        clk_i = 0, reset_i = 1;
   logic [25:0] nor_addr_o;
   logic [15:0] nor_data_o, nor_data_i;
   logic        nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o;
   logic        nor_ry_i = 1;
   logic [15:0] dq_val = 0, exp_dq = 0;
   int          cyc = 0, total = 0, bad = 0, acks = 0, viol = 0, ce_run = 0;
   int          oe_cnt = 0, we_cnt = 0, doe_cnt = 0, dq_bad = 0, min_gap = 1000;
   exp_t        q[$];
   exp_t        m_e;
   nor_bus_sequencer_if bus();
   nor_bus_sequencer #(.BUSY_TIMEOUT(20)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .wb(bus),
      .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe(nor_data_oe),
      .nor_data_i(nor_data_i), .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o),
      .nor_we_o(nor_we_o), .nor_ry_i(nor_ry_i)
   );
   assign nor_data_i = nor_oe_o ? 16'h0000 : dq_val;
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk_i);
   endtask
   task automatic drive(input logic on, input logic we, input logic [25:0] adr, input logic [15:0] dat, input logic wry);
      bus.wb_cyc_i  = on;
      bus.wb_stb_i  = on;
      bus.wb_we_i   = we;
      bus.wb_adr_i  = adr;
      bus.wb_dat_i  = dat;
      bus.wait_ry_i = wry;
   endtask
   task automatic expect_resp(input logic err, input logic chk, input logic [15:0] dat, input int due);
      q.push_back('{err, chk, dat, due});
   endtask
   task automatic clr;
      oe_cnt = 0;
      we_cnt = 0;
      doe_cnt = 0;
      dq_bad = 0;
   endtask
   // monitor: pad activity counters, invariants and scoreboard pops on ack/err
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (!nor_oe_o) oe_cnt++;
         if (!nor_we_o) we_cnt++;
         if (nor_data_oe) doe_cnt++;
         if (!nor_oe_o && !nor_we_o) viol++;
         if (nor_data_oe && nor_data_o !== exp_dq) dq_bad++;
         if (nor_ce_o) ce_run++;
         else begin
            if (ce_run > 0 && ce_run < min_gap) min_gap = ce_run;
            ce_run = 0;
         end
         if (bus.wb_ack_o || bus.wb_err_o) begin
            if (bus.wb_ack_o) acks++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b cyc=%0d", bus.wb_ack_o, bus.wb_err_o, cyc);
            end else begin
               m_e = q.pop_front();
               check("resp_kind", {bus.wb_ack_o, bus.wb_err_o}, {~m_e.err, m_e.err});
               check("resp_cycle", cyc, m_e.due);
               if (m_e.chk) check("rd_data", bus.wb_dat_o, m_e.dat);
            end
         end
      end
   end
   initial begin
      int c, a0;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk_i);
      check("rst_ce", nor_ce_o, 1);
      check("rst_oe", nor_oe_o, 1);
      check("rst_we", nor_we_o, 1);
      check("rst_doe", nor_data_oe, 0);
      check("rst_ack", bus.wb_ack_o, 0);
      check("rst_err", bus.wb_err_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_addr", nor_addr_o, 0);
      check("rst_data", nor_data_o, 0);
      check("rst_dat_o", bus.wb_dat_o, 0);
      reset_i = 0;
      @(negedge clk_i);
      // single read: ack 9 edges after the accepting edge
      c = cyc; clr(); dq_val = 16'hBEEF;
      drive(1, 0, 26'h155AA, 0, 0);
      expect_resp(0, 1, 16'hBEEF, c + 10);
      to_cyc(c + 2);
      check("rd_addr", nor_addr_o, 26'h155AA);
      check("rd_ce", nor_ce_o, 0);
      to_cyc(c + 10);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 14);
      check("rd_oe_cycles", oe_cnt, 6);
      check("rd_we_cycles", we_cnt, 0);
      check("rd_doe_cycles", doe_cnt, 0);
      check("rd_idle", bus.busy_o, 0);
      // unwaited write: ack 7 edges after accept
      c = cyc; clr(); exp_dq = 16'h0055;
      drive(1, 1, 26'h2AA, 16'h0055, 0);
      expect_resp(0, 0, 0, c + 8);
      to_cyc(c + 8);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 12);
      check("wr_we_cycles", we_cnt, 4);
      check("wr_doe_cycles", doe_cnt, 7);
      check("wr_oe_cycles", oe_cnt, 0);
      check("wr_dq_value", dq_bad, 0);
      // waited write: RY low 2 cycles after WE# rises, high 50 cycles later
      c = cyc; clr(); a0 = acks; exp_dq = 16'hA5A5;
      drive(1, 1, 26'h3000001, 16'hA5A5, 1);
      to_cyc(c + 9);
      nor_ry_i = 0;
      to_cyc(c + 59);
      nor_ry_i = 1;
      expect_resp(0, 0, 0, c + 62);
      to_cyc(c + 62);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 64);
      check("wry_busy_recover", bus.busy_o, 1);
      to_cyc(c + 65);
      check("wry_busy_idle", bus.busy_o, 0);
      check("wry_acks", acks - a0, 1);
      check("wry_we_cycles", we_cnt, 4);
      // back-to-back reads with stb held: accepts every 13 edges
      c = cyc; a0 = acks; min_gap = 1000; dq_val = 16'h1234;
      drive(1, 0, 26'h0ABCD, 0, 0);
      expect_resp(0, 1, 16'h1234, c + 10);
      expect_resp(0, 1, 16'h1234, c + 23);
      expect_resp(0, 1, 16'h1234, c + 36);
      to_cyc(c + 36);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 42);
      check("b2b_acks", acks - a0, 3);
      check("b2b_ce_gap", min_gap, 4);
      // abort: drop cyc during RD_STB, cycle completes with no ack
      c = cyc; clr(); a0 = acks;
      drive(1, 0, 26'h1, 0, 0);
      to_cyc(c + 5);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 14);
      check("abort_oe_cycles", oe_cnt, 6);
      check("abort_acks", acks - a0, 0);
      check("abort_idle", bus.busy_o, 0);
      // reset during WR_STB
      c = cyc; exp_dq = 16'h1111;
      drive(1, 1, 26'h2, 16'h1111, 0);
      to_cyc(c + 4);
      check("rstwr_we_low", nor_we_o, 0);
      reset_i = 1;
      to_cyc(c + 5);
      check("rstwr_ce", nor_ce_o, 1);
      check("rstwr_we", nor_we_o, 1);
      check("rstwr_doe", nor_data_oe, 0);
      check("rstwr_busy", bus.busy_o, 0);
      check("rstwr_ack", bus.wb_ack_o, 0);
      check("rstwr_addr", nor_addr_o, 0);
      reset_i = 0;
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 12);
      check("rstwr_idle", bus.busy_o, 0);
`ifdef NOR_BUSY_TIMEOUT_EN
      // RY stuck low: WAIT_RY expires after 20 cycles with an error pulse
      nor_ry_i = 0;
      c = cyc; a0 = acks; exp_dq = 16'h7777;
      drive(1, 1, 26'h5, 16'h7777, 1);
      expect_resp(1, 0, 0, c + 28);
      to_cyc(c + 28);
      drive(0, 0, 0, 0, 0);
      to_cyc(c + 32);
      check("to_idle", bus.busy_o, 0);
      check("to_acks", acks - a0, 0);
      nor_ry_i = 1;
`endif
      to_cyc(cyc + 4);
      check("oe_we_overlap", viol, 0);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
